// File: rtl/mul_share_arbiter_pkg.sv
// Shared types and constants for the multiplier-sharing arbiter.
//   mul_arb_state_e : controller states
//   mul_owner_t     : requester index (0 = integer M unit, 1 = FPU mantissa path)
//   mul_req_s       : request bundle at the default operand/tag widths
//   is_onehot2      : true when exactly one of two bits is set
package mul_share_arbiter_pkg;

    localparam int MUL_XLEN        = 32;
    localparam int MUL_TAG_W       = 4;
    // Cycles from request accept to resp_valid_o with a 10-cycle multiplier.
    localparam int MUL_NOMINAL_LAT = 11;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        BUSY,
        FLUSH,
        RESP
    } mul_arb_state_e;

    typedef logic mul_owner_t;

    typedef struct packed {
        logic [MUL_XLEN-1:0]  a;
        logic [MUL_XLEN-1:0]  b;
        logic [MUL_TAG_W-1:0] tag;
    } mul_req_s;

    function automatic logic is_onehot2(input logic [1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/mul_share_arbiter_rr_arbiter_2.sv
// Two-input round-robin grant, purely combinational.
//   i_ptr    : preferred requester when both request (0 = port 0)
//   i_req    : request vector, bit n = port n
//   o_grant  : grant vector, at most one bit set
//   o_onehot : a grant is being given this cycle
module rr_arbiter_2
    import mul_share_arbiter_pkg::*;
(
    input  logic       i_ptr,
    input  logic [1:0] i_req,
    output logic [1:0] o_grant,
    output logic       o_onehot
);

    always_comb begin
        o_grant = i_req;
        if (i_req == 2'b11) begin
            o_grant = i_ptr ? 2'b10 : 2'b01;
        end
    end

    assign o_onehot = is_onehot2(o_grant);

endmodule

// File: rtl/mul_share_arbiter.sv
// Time-shares one iterative signed multiplier between two requesters
// (port 0: integer M unit, port 1: FPU mantissa path). One operation is
// outstanding at a time; a watchdog flushes the multiplier and returns an
// error response when no result arrives.
//
// State | meaning
// IDLE  | waiting for a request, round-robin grant offered
// ISSUE | multiplier loads the captured operands, timer cleared
// BUSY  | multiplier running, timer counting up
// FLUSH | two cycles: multiplier reset asserted, then released with clock gated
// RESP  | response presented, held until resp_ready_i
//
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   req{0,1}_*                 requester valid/ready handshake, operands, tag
//   resp_*                     response handshake, owner, tag, product, error
//   mul_multiplier_o/_multiplicand_o, mul_clk_en_o, mul_rst_n_o
//                              operand and control outputs to the multiplier
//   mul_result_i, mul_valid_i  multiplier product and one-cycle done strobe
//   busy_o                     controller not idle
module mul_share_arbiter
    import mul_share_arbiter_pkg::*;
#(
    parameter int XLEN    = MUL_XLEN,
    parameter int TAG_W   = MUL_TAG_W,
    parameter int TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [XLEN-1:0]   req0_a_i,
    input  logic [XLEN-1:0]   req0_b_i,
    input  logic [TAG_W-1:0]  req0_tag_i,

    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [XLEN-1:0]   req1_a_i,
    input  logic [XLEN-1:0]   req1_b_i,
    input  logic [TAG_W-1:0]  req1_tag_i,

    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic              resp_owner_o,
    output logic [TAG_W-1:0]  resp_tag_o,
    output logic [2*XLEN-1:0] resp_result_o,
    output logic              resp_error_o,

    output logic [XLEN-1:0]   mul_multiplier_o,
    output logic [XLEN-1:0]   mul_multiplicand_o,
    output logic              mul_clk_en_o,
    output logic              mul_rst_n_o,
    input  logic [2*XLEN-1:0] mul_result_i,
    input  logic              mul_valid_i,

    output logic              busy_o
);

    localparam int               TMR_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    mul_arb_state_e    r_state;
    mul_owner_t        r_rr_ptr;
    mul_owner_t        r_owner;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [TAG_W-1:0]  r_tag;
    logic [2*XLEN-1:0] r_result;
    logic              r_error;
    logic [TMR_W-1:0]  r_timer;
    // Low in the first FLUSH cycle (reset asserted), high in the second.
    logic              r_flush_rel;

    logic [1:0]        w_grant;
    logic              w_grant_ok;
    logic              w_accept;

    rr_arbiter_2 u_rr (
        .i_ptr    (r_rr_ptr),
        .i_req    ({req1_valid_i, req0_valid_i}),
        .o_grant  (w_grant),
        .o_onehot (w_grant_ok)
    );

    assign w_accept     = (r_state == IDLE) && w_grant_ok;
    assign req0_ready_o = !rst_i && (r_state == IDLE) && w_grant[0];
    assign req1_ready_o = !rst_i && (r_state == IDLE) && w_grant[1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_rr_ptr    <= 1'b0;
            r_owner     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_tag       <= '0;
            r_result    <= '0;
            r_error     <= 1'b0;
            r_timer     <= '0;
            r_flush_rel <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_owner  <= w_grant[1];
                        r_rr_ptr <= !w_grant[1];
                        r_a      <= w_grant[1] ? req1_a_i   : req0_a_i;
                        r_b      <= w_grant[1] ? req1_b_i   : req0_b_i;
                        r_tag    <= w_grant[1] ? req1_tag_i : req0_tag_i;
                        r_result <= '0;
                        r_error  <= 1'b0;
                        r_state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_timer <= '0;
                    r_state <= BUSY;
                end
                BUSY: begin
                    r_timer <= r_timer + TMR_W'(1);
                    // A result arriving on the last allowed cycle still wins.
                    if (mul_valid_i) begin
                        r_result <= mul_result_i;
                        r_error  <= 1'b0;
                        r_state  <= RESP;
                    end else if (r_timer == TMR_LAST) begin
                        r_flush_rel <= 1'b0;
                        r_state     <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (!r_flush_rel) begin
                        r_flush_rel <= 1'b1;
                    end else begin
                        r_result <= '0;
                        r_error  <= 1'b1;
                        r_state  <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready_i) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign resp_valid_o       = (r_state == RESP);
    assign resp_owner_o       = r_owner;
    assign resp_tag_o         = r_tag;
    assign resp_result_o      = r_result;
    assign resp_error_o       = r_error;

    assign mul_multiplier_o   = r_a;
    assign mul_multiplicand_o = r_b;
    // Clock stays enabled through the BUSY cycle that sees mul_valid_i so the
    // multiplier can step back to its own idle state.
    assign mul_clk_en_o       = !rst_i && ((r_state == ISSUE) || (r_state == BUSY));
    assign mul_rst_n_o        = !rst_i && !((r_state == FLUSH) && !r_flush_rel);

    assign busy_o             = (r_state != IDLE);

endmodule

// File: tb/tb_mul_share_arbiter.sv
module tb_mul_share_arbiter;
    import mul_share_arbiter_pkg::*;

    localparam int T = 10;

    logic        clk_i;
    logic        rst_i;
    logic        req0_valid_i, req0_ready_o;
    logic [31:0] req0_a_i, req0_b_i;
    logic [3:0]  req0_tag_i;
    logic        req1_valid_i, req1_ready_o;
    logic [31:0] req1_a_i, req1_b_i;
    logic [3:0]  req1_tag_i;
    logic        resp_valid_o, resp_ready_i, resp_owner_o, resp_error_o;
    logic [3:0]  resp_tag_o;
    logic [63:0] resp_result_o;
    logic [31:0] mul_multiplier_o, mul_multiplicand_o;
    logic        mul_clk_en_o, mul_rst_n_o, mul_valid_i, busy_o;
    logic [63:0] mul_result_i;

    mul_share_arbiter #(.XLEN(32), .TAG_W(4), .TIMEOUT(T)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
        .req0_a_i(req0_a_i), .req0_b_i(req0_b_i), .req0_tag_i(req0_tag_i),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
        .req1_a_i(req1_a_i), .req1_b_i(req1_b_i), .req1_tag_i(req1_tag_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_owner_o(resp_owner_o), .resp_tag_o(resp_tag_o),
        .resp_result_o(resp_result_o), .resp_error_o(resp_error_o),
        .mul_multiplier_o(mul_multiplier_o), .mul_multiplicand_o(mul_multiplicand_o),
        .mul_clk_en_o(mul_clk_en_o), .mul_rst_n_o(mul_rst_n_o),
        .mul_result_i(mul_result_i), .mul_valid_i(mul_valid_i),
        .busy_o(busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // ---------------- multiplier stand-in ----------------
    int stub_lat  = 10;   // cycles from accept to mul_valid_i
    bit stub_hang = 0;    // never answer

    initial begin : mul_stub
        bit abort;
        int k;
        mul_valid_i  = 1'b0;
        mul_result_i = 64'h0BAD_0BAD_0BAD_0BAD;
        forever begin
            @(negedge clk_i);
            if (!rst_i && ((req0_valid_i && req0_ready_o) || (req1_valid_i && req1_ready_o))
                && !stub_hang) begin
                abort = 0;
                k = 1;
                while (k < stub_lat && !abort) begin
                    @(negedge clk_i);
                    if (rst_i) abort = 1;
                    k++;
                end
                if (!abort) begin
                    @(posedge clk_i); #1;
                    mul_valid_i  = 1'b1;
                    mul_result_i = 64'(longint'($signed(mul_multiplier_o)) *
                                       longint'($signed(mul_multiplicand_o)));
                    @(posedge clk_i); #1;
                    mul_valid_i  = 1'b0;
                    mul_result_i = 64'h0BAD_0BAD_0BAD_0BAD;
                end
            end
        end
    end

    // ---------------- transaction-level model + per-cycle compare ----------------
    // Phase 0: nothing outstanding; 1: operation in flight; 2: response owed.
    int          m_phase = 0;
    bit          m_ptr = 0;
    int          m_acc = 0;
    bit          m_owner;
    logic [3:0]  m_tag;
    logic [31:0] m_a, m_b;
    bit          m_to;
    bit          m_err;
    logic [63:0] m_result;
    bit          m_rst_prev = 0;

    always @(negedge clk_i) begin : compare
        int t;
        bit g0, g1;
        if (rst_i) begin
            chk("rst_mul_rst_n", 64'(mul_rst_n_o), 64'd0);
            chk("rst_ready", 64'({req1_ready_o, req0_ready_o}), 64'd0);
            m_phase    = 0;
            m_ptr      = 0;
            m_rst_prev = 1;
        end else begin
            if (m_rst_prev) begin
                chk("rv_resp_valid", 64'(resp_valid_o), 64'd0);
                chk("rv_error", 64'(resp_error_o), 64'd0);
                chk("rv_result", resp_result_o, 64'd0);
                chk("rv_tag", 64'(resp_tag_o), 64'd0);
                chk("rv_owner", 64'(resp_owner_o), 64'd0);
                chk("rv_operands", 64'({mul_multiplier_o, mul_multiplicand_o}), 64'd0);
                chk("rv_clk_en", 64'(mul_clk_en_o), 64'd0);
                chk("rv_busy", 64'(busy_o), 64'd0);
            end
            m_rst_prev = 0;
            t  = cyc - m_acc;
            g0 = 0;
            g1 = 0;
            if (m_phase == 0) begin
                if (req0_valid_i && (!req1_valid_i || !m_ptr)) g0 = 1;
                else if (req1_valid_i) g1 = 1;
            end
            chk("ready0", 64'(req0_ready_o), 64'(g0));
            chk("ready1", 64'(req1_ready_o), 64'(g1));
            chk("busy", 64'(busy_o), 64'(m_phase != 0));
            chk("clk_en", 64'(mul_clk_en_o), 64'(m_phase == 1 && !m_to && t >= 1));
            chk("mul_rst_n", 64'(mul_rst_n_o), 64'(!(m_phase == 1 && m_to && t == T + 2)));
            chk("resp_valid", 64'(resp_valid_o), 64'(m_phase == 2));
            if (m_phase != 0) begin
                chk("operand_a", 64'(mul_multiplier_o), 64'(m_a));
                chk("operand_b", 64'(mul_multiplicand_o), 64'(m_b));
            end
            if (m_phase == 2) begin
                chk("resp_owner", 64'(resp_owner_o), 64'(m_owner));
                chk("resp_tag", 64'(resp_tag_o), 64'(m_tag));
                chk("resp_result", resp_result_o, m_result);
                chk("resp_error", 64'(resp_error_o), 64'(m_err));
            end
            case (m_phase)
                0: if (g0 || g1) begin
                    m_owner = g1;
                    m_a     = g1 ? req1_a_i : req0_a_i;
                    m_b     = g1 ? req1_b_i : req0_b_i;
                    m_tag   = g1 ? req1_tag_i : req0_tag_i;
                    m_ptr   = !g1;
                    m_acc   = cyc;
                    m_to    = 0;
                    m_phase = 1;
                end
                1: if (!m_to) begin
                    if (t >= 2 && mul_valid_i) begin
                        m_result = 64'(longint'($signed(m_a)) * longint'($signed(m_b)));
                        m_err    = 0;
                        m_phase  = 2;
                    end else if (t == T + 1) begin
                        m_to = 1;
                    end
                end else if (t == T + 3) begin
                    m_result = 64'd0;
                    m_err    = 1;
                    m_phase  = 2;
                end
                2: if (resp_ready_i) m_phase = 0;
                default: m_phase = 0;
            endcase
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_req0(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        mul_req_s q;
        q = '{a: a, b: b, tag: tag};
        req0_a_i = q.a; req0_b_i = q.b; req0_tag_i = q.tag;
    endtask

    task automatic set_req1(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        mul_req_s q;
        q = '{a: a, b: b, tag: tag};
        req1_a_i = q.a; req1_b_i = q.b; req1_tag_i = q.tag;
    endtask

    task automatic wait_accept(output int acc, output bit own);
        bit got;
        got = 0; acc = -1; own = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk_i);
            if (req0_valid_i && req0_ready_o) begin got = 1; own = 0; acc = cyc; end
            else if (req1_valid_i && req1_ready_o) begin got = 1; own = 1; acc = cyc; end
        end
        if (!got) chk("accept_wait_expired", 64'd0, 64'd1);
    endtask

    task automatic wait_resp(output int rc);
        bit got;
        got = 0; rc = -1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk_i);
            if (resp_valid_o) begin got = 1; rc = cyc; end
        end
        if (!got) chk("resp_wait_expired", 64'd0, 64'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int acc, rc, lowcnt, lowcyc, hs;
        bit own, seen;
        bit owners [4];

        rst_i = 1'b1;
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        set_req0('0, '0, '0);
        set_req1('0, '0, '0);
        resp_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;

        // single op on port 0: 7 * -3
        @(posedge clk_i); #1;
        set_req0(32'd7, 32'hFFFF_FFFD, 4'd5); req0_valid_i = 1'b1;
        wait_accept(acc, own);
        chk("t1_owner_at_accept", 64'(own), 64'd0);
        @(posedge clk_i); #1 req0_valid_i = 1'b0;
        wait_resp(rc);
        chk("t1_latency", 64'(rc - acc), 64'd11);
        chk("t1_result", resp_result_o, 64'hFFFF_FFFF_FFFF_FFEB);
        chk("t1_owner", 64'(resp_owner_o), 64'd0);
        chk("t1_tag", 64'(resp_tag_o), 64'd5);
        chk("t1_error", 64'(resp_error_o), 64'd0);

        // backpressure on a port 1 op: -5 * 100
        @(posedge clk_i); #1;
        resp_ready_i = 1'b0;
        set_req1(32'hFFFF_FFFB, 32'd100, 4'd3); req1_valid_i = 1'b1;
        wait_accept(acc, own);
        chk("bp_owner_at_accept", 64'(own), 64'd1);
        @(posedge clk_i); #1 req1_valid_i = 1'b0;
        wait_resp(rc);
        @(posedge clk_i); #1;
        set_req0(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hF); req0_valid_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            chk("bp_valid", 64'(resp_valid_o), 64'd1);
            chk("bp_result", resp_result_o, 64'hFFFF_FFFF_FFFF_FE0C);
            chk("bp_tag_owner", 64'({resp_tag_o, resp_owner_o}), 64'({4'd3, 1'b1}));
            chk("bp_req0_ready", 64'(req0_ready_o), 64'd0);
        end
        @(posedge clk_i); #1;
        req0_valid_i = 1'b0; resp_ready_i = 1'b1;
        hs = 0;
        repeat (5) begin
            @(negedge clk_i);
            if (resp_valid_o && resp_ready_i) hs++;
        end
        chk("bp_handshakes", 64'(hs), 64'd1);

        // both ports requesting continuously
        @(posedge clk_i); #1;
        set_req0(32'd3, 32'd4, 4'd1);
        set_req1(32'h8000_0000, 32'h8000_0000, 4'd9);
        req0_valid_i = 1'b1; req1_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_accept(acc, own);
            owners[i] = own;
            if (i == 3) begin
                @(posedge clk_i); #1;
                req0_valid_i = 1'b0; req1_valid_i = 1'b0;
            end
            wait_resp(rc);
            chk("rr_latency", 64'(rc - acc), 64'd11);
            chk("rr_result", resp_result_o, own ? 64'h4000_0000_0000_0000 : 64'd12);
            chk("rr_tag", 64'(resp_tag_o), own ? 64'd9 : 64'd1);
        end
        chk("rr_grant0", 64'(owners[0]), 64'd0);
        chk("rr_grant1", 64'(owners[1]), 64'd1);
        chk("rr_grant2", 64'(owners[2]), 64'd0);
        chk("rr_grant3", 64'(owners[3]), 64'd1);

        // watchdog timeout
        @(posedge clk_i); #1;
        stub_hang = 1;
        set_req0(32'd11, 32'd13, 4'd2); req0_valid_i = 1'b1;
        wait_accept(acc, own);
        @(posedge clk_i); #1 req0_valid_i = 1'b0;
        lowcnt = 0; lowcyc = -1; seen = 0; rc = -1;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk_i);
            if (!mul_rst_n_o) begin lowcnt++; lowcyc = cyc; end
            if (resp_valid_o) begin seen = 1; rc = cyc; end
        end
        chk("to_resp_seen", 64'(seen), 64'd1);
        chk("to_rst_low_cycles", 64'(lowcnt), 64'd1);
        chk("to_rst_low_at", 64'(lowcyc - acc), 64'(T + 2));
        chk("to_resp_at", 64'(rc - acc), 64'(T + 4));
        chk("to_error", 64'(resp_error_o), 64'd1);
        chk("to_result", resp_result_o, 64'd0);
        chk("to_tag", 64'(resp_tag_o), 64'd2);
        @(posedge clk_i); #1;
        stub_hang = 0;
        set_req1(32'd2, 32'd3, 4'd7); req1_valid_i = 1'b1;
        wait_accept(acc, own);
        @(posedge clk_i); #1 req1_valid_i = 1'b0;
        wait_resp(rc);
        chk("after_to_latency", 64'(rc - acc), 64'd11);
        chk("after_to_result", resp_result_o, 64'd6);
        chk("after_to_error", 64'(resp_error_o), 64'd0);

        // reset in the middle of BUSY (port 0 op leaves the pointer at 1)
        @(posedge clk_i); #1;
        set_req0(32'd5, 32'd6, 4'd4); req0_valid_i = 1'b1;
        wait_accept(acc, own);
        @(posedge clk_i); #1 req0_valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(posedge clk_i); #1 rst_i = 1'b0;
        hs = 0;
        repeat (15) begin
            @(negedge clk_i);
            if (resp_valid_o) hs++;
        end
        chk("rst_no_resp", 64'(hs), 64'd0);
        @(posedge clk_i); #1;
        set_req0(32'd9, 32'd9, 4'hA);
        set_req1(32'd1, 32'd1, 4'hB);
        req0_valid_i = 1'b1; req1_valid_i = 1'b1;
        wait_accept(acc, own);
        chk("rst_tie_owner", 64'(own), 64'd0);
        @(posedge clk_i); #1;
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        wait_resp(rc);
        chk("rst_next_result", resp_result_o, 64'd81);

        // result on the final BUSY cycle beats the timeout
        @(posedge clk_i); #1;
        stub_lat = T + 1;
        set_req0(32'hFFFF_FFF9, 32'd9, 4'd6); req0_valid_i = 1'b1;
        wait_accept(acc, own);
        @(posedge clk_i); #1 req0_valid_i = 1'b0;
        lowcnt = 0; seen = 0; rc = -1;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk_i);
            if (!mul_rst_n_o) lowcnt++;
            if (resp_valid_o) begin seen = 1; rc = cyc; end
        end
        chk("co_latency", 64'(rc - acc), 64'd12);
        chk("co_error", 64'(resp_error_o), 64'd0);
        chk("co_result", resp_result_o, 64'hFFFF_FFFF_FFFF_FFC1);
        chk("co_no_flush", 64'(lowcnt), 64'd0);
        stub_lat = 10;

        repeat (3) @(posedge clk_i);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
